matching_unit: RTL and testbench
================================

Name: matching_unit

Overview:
- Sits directly downstream of function_expander and the other packet-request producers.
- Consumes PACKET_REQUEST words and pairs LEFT/RIGHT operands that carry the same (dest_addr, color) tag.
- Emits a matched operand pair to the instruction-fetch stage.
- Single-operand (ONE) requests bypass the store; NOP requests are consumed and discarded.

Parameters:
- DEPTH, 8: number of matching-store entries (2..64).
- IDX_W, 3: log2(DEPTH); width of OCCUPANCY is IDX_W+1.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- RECEIVE_PR_VALID  in  1  request valid.
- RECEIVE_PR_DATA  in  PACKET_REQUEST_WIDTH  {dest_option[2:0], dest_addr[15:0], color[15:0], data1[31:0], data2[31:0]}.
- RECEIVE_PR_READY  out  1  request accepted.
- SEND_MP_VALID  out  1  matched pair valid.
- SEND_MP_DATA  out  96  {dest_addr[15:0], color[15:0], left[31:0], right[31:0]}.
- SEND_MP_READY  in  1  consumer accepts.
- OCCUPANCY  out  IDX_W+1  number of valid entries.
- OVERFLOW  out  1  sticky: a request was dropped because the store was full.

Behaviour:
- Reset: all entries invalid; RECEIVE_PR_READY=0, SEND_MP_VALID=0, SEND_MP_DATA=0, OCCUPANCY=0, OVERFLOW=0; FSM enters S_IDLE. RST asserted mid-operation aborts any held request or output in that cycle, and its effect is visible on the next edge.
- Handshake: a transfer occurs on a rising edge with VALID&&READY. SEND_MP_VALID and SEND_MP_DATA stay stable until accepted.
- FSM states: S_IDLE, S_MATCH, S_SEND.
- S_IDLE:
  - RECEIVE_PR_READY=1.
  - On transfer, latch the request into req_r and go to S_MATCH.
- S_MATCH (RECEIVE_PR_READY=0), action by dest_option:
  - DEST_OPTION_NOP: discard; go to S_IDLE.
  - DEST_OPTION_ONE: out = {addr, color, data1, data2}; go to S_SEND.
  - DEST_OPTION_LEFT or DEST_OPTION_RIGHT: compare req_r against every valid entry with equal addr, equal color and opposite side. The lowest-index hit wins.
    - Hit: out.left = data1 of the LEFT operand, out.right = data1 of the RIGHT operand. Invalidate the entry, decrement OCCUPANCY, go to S_SEND.
    - Miss with a free slot: write {addr, color, side, data1} into the lowest-index free slot, increment OCCUPANCY, go to S_IDLE.
    - Miss with the store full: drop the request, set OVERFLOW, go to S_IDLE.
  - Any other option value is treated as NOP.
  - data2 is ignored for LEFT/RIGHT requests.
- S_SEND:
  - SEND_MP_VALID=1.
  - On SEND_MP_READY, go to S_IDLE.
- Latency: accept at edge T; output valid after edge T+1; earliest next accept at edge T+3. A NOP or miss can be followed by the next accept at T+2.
- A same-side duplicate tag is stored as a separate entry; a later opposite operand pairs with the lowest index.
- OCCUPANCY never exceeds DEPTH and never wraps. OVERFLOW clears only on RST.

Optional Feature:
- MATCHING_UNIT_STATS_EN defined: adds outputs HIT_COUNT[31:0], MISS_COUNT[31:0] and ONE_COUNT[31:0], all cleared on RST.
  - The relevant counter increments once per S_MATCH outcome.
  - Counters saturate at 32'hFFFFFFFF.
  - Dropped requests count as misses.
- Macro undefined: these ports and registers are absent. Behaviour is otherwise identical.

Decomposition:
- The shared parameter include holds:
  - DEST_OPTION_* encodings.
  - PACKET_REQUEST_WIDTH and a new MATCHED_PACKET_WIDTH=96.
  - Field offsets.
  - make_matched_packet construction function, next to make_packet_request.
- One sub-module, matching_store: an entry array providing parallel tag compare, lowest-index hit and free-slot priority encoders, and insert/invalidate ports.
- The FSM and output register stay in matching_unit.

Test Plan:
- RIGHT {addr=16'h0040, color=16'h0003, data1=32'hAAAA0001}, then LEFT with the same tag and data1=32'h5555_0002 -> one output {0040, 0003, 55550002, AAAA0001}; OCCUPANCY goes 0->1->0.
- ONE {addr=16'h0010, color=16'h0001, data1=32'h1, data2=32'h2} -> output {0010, 0001, 1, 2} two edges after accept; OCCUPANCY stays 0.
- NOP request -> no output; RECEIVE_PR_READY returns high two edges after accept.
- DEPTH+1 LEFT requests with distinct colors 0..8 -> OCCUPANCY=8, OVERFLOW=1; the color-8 request is lost; RIGHT with color 0 still pairs.
- Two LEFTs with the same tag (data1=11, then 22), then one RIGHT (data1=33) -> output left=11, right=33; OCCUPANCY=1.
- SEND_MP_READY held low for 5 cycles -> SEND_MP_VALID and SEND_MP_DATA stable, RECEIVE_PR_READY=0 throughout; assert RST during the stall -> all outputs 0 next edge.

Source files
------------

// File: rtl/matching_unit_pkg.sv
// Shared encodings, packet layouts and packet construction helpers for the matching unit.
// The optional MATCHING_UNIT_STATS_EN build adds statistics counters in matching_unit.
package matching_unit_pkg;

    localparam int DEST_OPTION_W = 3;
    localparam int ADDR_W        = 16;
    localparam int COLOR_W       = 16;
    localparam int DATA_W        = 32;

    localparam logic [DEST_OPTION_W-1:0] DEST_OPTION_NOP   = 3'd0;
    localparam logic [DEST_OPTION_W-1:0] DEST_OPTION_ONE   = 3'd1;
    localparam logic [DEST_OPTION_W-1:0] DEST_OPTION_LEFT  = 3'd2;
    localparam logic [DEST_OPTION_W-1:0] DEST_OPTION_RIGHT = 3'd3;

    localparam int PACKET_REQUEST_WIDTH = DEST_OPTION_W + ADDR_W + COLOR_W + 2 * DATA_W;
    localparam int MATCHED_PACKET_WIDTH = ADDR_W + COLOR_W + 2 * DATA_W;

    // Request layout: {dest_option, dest_addr, color, data1, data2}
    localparam int PR_DATA2_LSB = 0;
    localparam int PR_DATA1_LSB = PR_DATA2_LSB + DATA_W;
    localparam int PR_COLOR_LSB = PR_DATA1_LSB + DATA_W;
    localparam int PR_ADDR_LSB  = PR_COLOR_LSB + COLOR_W;
    localparam int PR_OPT_LSB   = PR_ADDR_LSB + ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MATCH,
        S_SEND
    } state_t;

    function automatic logic [PACKET_REQUEST_WIDTH-1:0] make_packet_request(
        input logic [DEST_OPTION_W-1:0] opt,
        input logic [ADDR_W-1:0]        addr,
        input logic [COLOR_W-1:0]       color,
        input logic [DATA_W-1:0]        data1,
        input logic [DATA_W-1:0]        data2
    );
        return {opt, addr, color, data1, data2};
    endfunction

    function automatic logic [MATCHED_PACKET_WIDTH-1:0] make_matched_packet(
        input logic [ADDR_W-1:0]  addr,
        input logic [COLOR_W-1:0] color,
        input logic [DATA_W-1:0]  left,
        input logic [DATA_W-1:0]  right
    );
        return {addr, color, left, right};
    endfunction

endpackage

// File: rtl/matching_store.sv
// Matching-store entry array: parallel tag compare with lowest-index hit select,
// lowest-index free-slot select, insert/invalidate enables and live occupancy count.
module matching_store
    import matching_unit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [COLOR_W-1:0] color,
    input  logic               side,
    input  logic [DATA_W-1:0]  data,
    input  logic               insert,
    input  logic               invalidate,
    output logic               hit,
    output logic [DATA_W-1:0]  hit_data,
    output logic               free,
    output logic [IDX_W:0]     occupancy
);

    logic [DEPTH-1:0]   valid;
    logic [ADDR_W-1:0]  entry_addr  [DEPTH];
    logic [COLOR_W-1:0] entry_color [DEPTH];
    logic               entry_side  [DEPTH];
    logic [DATA_W-1:0]  entry_data  [DEPTH];

    logic [IDX_W-1:0]   hit_idx;
    logic [IDX_W-1:0]   free_idx;

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        free      = 1'b0;
        free_idx  = '0;
        occupancy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && entry_addr[i] == addr && entry_color[i] == color &&
                entry_side[i] != side) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
            occupancy = occupancy + (IDX_W + 1)'(valid[i]);
        end
    end

    assign hit_data = entry_data[hit_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (invalidate && hit) begin
                valid[hit_idx] <= 1'b0;
            end
            if (insert && free) begin
                valid[free_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (insert && free) begin
            entry_addr[free_idx]  <= addr;
            entry_color[free_idx] <= color;
            entry_side[free_idx]  <= side;
            entry_data[free_idx]  <= data;
        end
    end

endmodule

// File: rtl/matching_unit.sv
// Pairs LEFT/RIGHT operands sharing a (dest_addr, color) tag; ONE requests bypass the store.
// Defining MATCHING_UNIT_STATS_EN adds saturating HIT/MISS/ONE counters.
module matching_unit
    import matching_unit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            RECEIVE_PR_VALID,
    input  logic [PACKET_REQUEST_WIDTH-1:0] RECEIVE_PR_DATA,
    output logic                            RECEIVE_PR_READY,
    output logic                            SEND_MP_VALID,
    output logic [MATCHED_PACKET_WIDTH-1:0] SEND_MP_DATA,
    input  logic                            SEND_MP_READY,
    output logic [IDX_W:0]                  OCCUPANCY,
    output logic                            OVERFLOW
`ifdef MATCHING_UNIT_STATS_EN
    ,
    output logic [31:0]                     HIT_COUNT,
    output logic [31:0]                     MISS_COUNT,
    output logic [31:0]                     ONE_COUNT
`endif
);

    state_t state;
    state_t next_state;

    logic [PACKET_REQUEST_WIDTH-1:0] req_r;
    logic                            ready_r;
    logic                            valid_r;
    logic                            overflow_r;
    logic [MATCHED_PACKET_WIDTH-1:0] mp_data_r;

    logic [DEST_OPTION_W-1:0] req_opt;
    logic [ADDR_W-1:0]        req_addr;
    logic [COLOR_W-1:0]       req_color;
    logic [DATA_W-1:0]        req_data1;
    logic [DATA_W-1:0]        req_data2;
    logic                     req_side;
    logic                     req_pair;

    logic                     hit;
    logic [DATA_W-1:0]        hit_data;
    logic                     free;

    logic                            load_out;
    logic [MATCHED_PACKET_WIDTH-1:0] out_next;
    logic                            do_insert;
    logic                            do_invalidate;
    logic                            set_overflow;

    assign req_opt   = req_r[PR_OPT_LSB   +: DEST_OPTION_W];
    assign req_addr  = req_r[PR_ADDR_LSB  +: ADDR_W];
    assign req_color = req_r[PR_COLOR_LSB +: COLOR_W];
    assign req_data1 = req_r[PR_DATA1_LSB +: DATA_W];
    assign req_data2 = req_r[PR_DATA2_LSB +: DATA_W];
    assign req_side  = (req_opt == DEST_OPTION_RIGHT);
    assign req_pair  = (req_opt == DEST_OPTION_LEFT) || (req_opt == DEST_OPTION_RIGHT);

    matching_store #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_store (
        .clk        (CLK),
        .rst        (RST),
        .addr       (req_addr),
        .color      (req_color),
        .side       (req_side),
        .data       (req_data1),
        .insert     (do_insert),
        .invalidate (do_invalidate),
        .hit        (hit),
        .hit_data   (hit_data),
        .free       (free),
        .occupancy  (OCCUPANCY)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        load_out      = 1'b0;
        out_next      = '0;
        do_insert     = 1'b0;
        do_invalidate = 1'b0;
        set_overflow  = 1'b0;
        case (state)
            S_IDLE: begin
                if (RECEIVE_PR_VALID && ready_r) begin
                    next_state = S_MATCH;
                end
            end
            S_MATCH: begin
                next_state = S_IDLE;
                if (req_opt == DEST_OPTION_ONE) begin
                    load_out   = 1'b1;
                    out_next   = make_matched_packet(req_addr, req_color, req_data1, req_data2);
                    next_state = S_SEND;
                end else if (req_pair) begin
                    if (hit) begin
                        load_out      = 1'b1;
                        do_invalidate = 1'b1;
                        next_state    = S_SEND;
                        out_next      = req_side
                            ? make_matched_packet(req_addr, req_color, hit_data, req_data1)
                            : make_matched_packet(req_addr, req_color, req_data1, hit_data);
                    end else if (free) begin
                        do_insert = 1'b1;
                    end else begin
                        set_overflow = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (SEND_MP_READY) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RECEIVE_PR_VALID && ready_r) begin
            req_r <= RECEIVE_PR_DATA;
        end
    end

    // Handshake flags are registered from next_state so they drop to zero on the reset edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ready_r    <= 1'b0;
            valid_r    <= 1'b0;
            mp_data_r  <= '0;
            overflow_r <= 1'b0;
        end else begin
            ready_r <= (next_state == S_IDLE);
            valid_r <= (next_state == S_SEND);
            if (load_out) begin
                mp_data_r <= out_next;
            end
            if (set_overflow) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign RECEIVE_PR_READY = ready_r;
    assign SEND_MP_VALID    = valid_r;
    assign SEND_MP_DATA     = mp_data_r;
    assign OVERFLOW         = overflow_r;

`ifdef MATCHING_UNIT_STATS_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;
    logic [31:0] one_count_r;
    logic        hit_evt;
    logic        miss_evt;
    logic        one_evt;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    assign hit_evt  = (state == S_MATCH) && req_pair && hit;
    assign miss_evt = (state == S_MATCH) && req_pair && !hit;
    assign one_evt  = (state == S_MATCH) && (req_opt == DEST_OPTION_ONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_r  <= '0;
            miss_count_r <= '0;
            one_count_r  <= '0;
        end else begin
            if (hit_evt) begin
                hit_count_r <= sat_inc(hit_count_r);
            end
            if (miss_evt) begin
                miss_count_r <= sat_inc(miss_count_r);
            end
            if (one_evt) begin
                one_count_r <= sat_inc(one_count_r);
            end
        end
    end

    assign HIT_COUNT  = hit_count_r;
    assign MISS_COUNT = miss_count_r;
    assign ONE_COUNT  = one_count_r;
`endif

endmodule

// File: tb/tb_matching_unit.sv
// Scoreboard bench for matching_unit: directed requests push expected pairs, a monitor pops them.
module tb_matching_unit;
    import matching_unit_pkg::*;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic                            CLK = 1'b0;
    logic                            RST;
    logic                            RECEIVE_PR_VALID;
    logic [PACKET_REQUEST_WIDTH-1:0] RECEIVE_PR_DATA;
    logic                            RECEIVE_PR_READY;
    logic                            SEND_MP_VALID;
    logic [MATCHED_PACKET_WIDTH-1:0] SEND_MP_DATA;
    logic                            SEND_MP_READY;
    logic [IDX_W:0]                  OCCUPANCY;
    logic                            OVERFLOW;

    int total = 0;
    int bad   = 0;
    logic [MATCHED_PACKET_WIDTH-1:0] sb_q[$];

    always #5 CLK = ~CLK;

    matching_unit #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .RECEIVE_PR_VALID (RECEIVE_PR_VALID),
        .RECEIVE_PR_DATA  (RECEIVE_PR_DATA),
        .RECEIVE_PR_READY (RECEIVE_PR_READY),
        .SEND_MP_VALID    (SEND_MP_VALID),
        .SEND_MP_DATA     (SEND_MP_DATA),
        .SEND_MP_READY    (SEND_MP_READY),
        .OCCUPANCY        (OCCUPANCY),
        .OVERFLOW         (OVERFLOW)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output must match the oldest expected pair.
    always @(negedge CLK) begin
        if (!RST && SEND_MP_VALID && SEND_MP_READY) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %0h expected no output", SEND_MP_DATA);
            end else begin
                check("mp_data", SEND_MP_DATA, sb_q.pop_front());
            end
        end
    end

    task automatic send(input logic [2:0] opt, input logic [15:0] a, input logic [15:0] c,
                        input logic [31:0] d1, input logic [31:0] d2);
        int n = 0;
        @(negedge CLK);
        while (!RECEIVE_PR_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!RECEIVE_PR_READY) begin
            total++;
            bad++;
            $display("FAIL send_timeout: ready got 0 expected 1");
        end
        RECEIVE_PR_VALID = 1'b1;
        RECEIVE_PR_DATA  = make_packet_request(opt, a, c, d1, d2);
        @(posedge CLK);
        #1;
        RECEIVE_PR_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while ((!RECEIVE_PR_READY || SEND_MP_VALID) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!RECEIVE_PR_READY || SEND_MP_VALID) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: ready=%0b valid=%0b expected 1/0", RECEIVE_PR_READY, SEND_MP_VALID);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST              = 1'b1;
        RECEIVE_PR_VALID = 1'b0;
        RECEIVE_PR_DATA  = '0;
        SEND_MP_READY    = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready", RECEIVE_PR_READY, 0);
        check("rst_valid", SEND_MP_VALID, 0);
        check("rst_data", SEND_MP_DATA, 0);
        check("rst_occ", OCCUPANCY, 0);
        check("rst_ovf", OVERFLOW, 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("ready_after_rst", RECEIVE_PR_READY, 1);

        // RIGHT stored, then LEFT with same tag pairs
        send(DEST_OPTION_RIGHT, 16'h0040, 16'h0003, 32'hAAAA0001, 32'h0);
        wait_idle();
        check("occ_pair_1", OCCUPANCY, 1);
        sb_q.push_back({16'h0040, 16'h0003, 32'h55550002, 32'hAAAA0001});
        send(DEST_OPTION_LEFT, 16'h0040, 16'h0003, 32'h55550002, 32'h0);
        wait_idle();
        check("occ_pair_0", OCCUPANCY, 0);

        // ONE bypass with latency check
        sb_q.push_back({16'h0010, 16'h0001, 32'h1, 32'h2});
        send(DEST_OPTION_ONE, 16'h0010, 16'h0001, 32'h1, 32'h2);
        @(negedge CLK);
        check("one_valid_t0", SEND_MP_VALID, 0);
        @(negedge CLK);
        check("one_valid_t1", SEND_MP_VALID, 1);
        wait_idle();
        check("one_occ", OCCUPANCY, 0);

        // NOP consumed, no output
        send(DEST_OPTION_NOP, 16'h0020, 16'h0002, 32'h3, 32'h4);
        @(negedge CLK);
        check("nop_ready_t0", RECEIVE_PR_READY, 0);
        @(negedge CLK);
        check("nop_ready_t1", RECEIVE_PR_READY, 1);
        check("nop_valid", SEND_MP_VALID, 0);

        // Fill the store and overflow
        for (int c = 0; c <= DEPTH; c++) begin
            send(DEST_OPTION_LEFT, 16'h0100, 16'(c), 32'h100 + 32'(c), 32'h0);
            wait_idle();
        end
        check("full_occ", OCCUPANCY, 8);
        check("full_ovf", OVERFLOW, 1);
        sb_q.push_back({16'h0100, 16'h0000, 32'h00000100, 32'h0000BEEF});
        send(DEST_OPTION_RIGHT, 16'h0100, 16'h0000, 32'h0000BEEF, 32'h0);
        wait_idle();
        check("full_pair_occ", OCCUPANCY, 7);
        send(DEST_OPTION_RIGHT, 16'h0100, 16'h0008, 32'h000000D8, 32'h0);
        wait_idle();
        check("lost_color8_occ", OCCUPANCY, 8);
        check("ovf_sticky", OVERFLOW, 1);

        // Output stall, then reset in the middle of it
        SEND_MP_READY = 1'b0;
        send(DEST_OPTION_ONE, 16'h0030, 16'h0007, 32'hCAFE0001, 32'hCAFE0002);
        n = 0;
        @(negedge CLK);
        while (!SEND_MP_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", SEND_MP_VALID, 1);
            check("stall_data", SEND_MP_DATA, {16'h0030, 16'h0007, 32'hCAFE0001, 32'hCAFE0002});
            check("stall_ready", RECEIVE_PR_READY, 0);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("midrst_valid", SEND_MP_VALID, 0);
        check("midrst_data", SEND_MP_DATA, 0);
        check("midrst_ready", RECEIVE_PR_READY, 0);
        check("midrst_occ", OCCUPANCY, 0);
        check("midrst_ovf", OVERFLOW, 0);
        #1 RST = 1'b0;
        SEND_MP_READY = 1'b1;
        wait_idle();

        // Same-side duplicates pair in store order
        send(DEST_OPTION_LEFT, 16'h0200, 16'h0005, 32'd11, 32'h0);
        wait_idle();
        send(DEST_OPTION_LEFT, 16'h0200, 16'h0005, 32'd22, 32'h0);
        wait_idle();
        check("dup_occ_2", OCCUPANCY, 2);
        sb_q.push_back({16'h0200, 16'h0005, 32'd11, 32'd33});
        send(DEST_OPTION_RIGHT, 16'h0200, 16'h0005, 32'd33, 32'h0);
        wait_idle();
        check("dup_occ_1", OCCUPANCY, 1);
        sb_q.push_back({16'h0200, 16'h0005, 32'd22, 32'd44});
        send(DEST_OPTION_RIGHT, 16'h0200, 16'h0005, 32'd44, 32'h0);
        wait_idle();
        check("dup_occ_0", OCCUPANCY, 0);

        repeat (5) @(negedge CLK);
        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
